// File: rtl/acc_alu_pkg.sv
// Shared opcode and FSM state types for the accumulating ALU.
package acc_alu_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpMul  = 3'd2,
        OpDiv  = 3'd3,
        OpLoad = 3'd4,
        OpClr  = 3'd5
    } op_e;

    typedef enum logic {
        StIdle,
        StDiv
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, WIDTH cycles after start.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next, quo_next;

    // The remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
    end

    // Quotient is presented combinationally so the caller can capture it on the final edge.
    assign done     = (cnt_q == CntW'(1));
    assign quotient = quo_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= CntW'(WIDTH);
        end else if (cnt_q != '0) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/acc_alu.sv
// Accumulating ALU: each accepted command folds the operand into the accumulator.
module acc_alu
    import acc_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             res_valid,
    output logic             ovf,
    output logic             dz
);

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic               accept, div_start, div_done;
    logic [WIDTH-1:0]   div_quotient;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;

    assign in_ready  = (state_q == StIdle) && !reset;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (op_e'(op) == OpDiv) && (operand != '0);
    assign result    = acc_q;

    assign sum  = {1'b0, acc_q} + {1'b0, operand};
    assign diff = {1'b0, acc_q} - {1'b0, operand};
    assign prod = (2*WIDTH)'(acc_q) * (2*WIDTH)'(operand);

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(acc_q),
        .divisor (operand),
        .done    (div_done),
        .quotient(div_quotient)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            res_valid <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (div_start) begin
                        state_q <= StDiv;
                    end else if (accept) begin
                        res_valid <= 1'b1;
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                        case (op_e'(op))
                            OpAdd: begin
                                acc_q <= sum[WIDTH-1:0];
                                ovf   <= sum[WIDTH];
                            end
                            OpSub: begin
                                acc_q <= diff[WIDTH-1:0];
                                ovf   <= diff[WIDTH];
                            end
                            OpMul: begin
                                acc_q <= prod[WIDTH-1:0];
                                ovf   <= |prod[2*WIDTH-1:WIDTH];
                            end
                            // Only a zero divisor reaches here; nonzero ones go to StDiv.
                            OpDiv: begin
                                acc_q <= '1;
                                dz    <= 1'b1;
                            end
                            OpLoad:  acc_q <= operand;
                            OpClr:   acc_q <= '0;
                            default: acc_q <= acc_q;
                        endcase
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        acc_q     <= div_quotient;
                        res_valid <= 1'b1;
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_alu.sv
// Bench for acc_alu: directed scenarios plus random commands against an arithmetic model.
module tb_acc_alu;
    import acc_alu_pkg::*;

    localparam int unsigned W = 16;
    localparam longint Mod = 64'd1 << W;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, res_valid, ovf, dz;
    logic [2:0]   op;
    logic [W-1:0] operand, result;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: accumulator, pending quotient, busy cycles left, last completion flags.
    longint m_a, m_pend;
    int     m_busy;
    bit     m_valid, m_ovf, m_dz;

    acc_alu #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand  (operand),
        .result   (result),
        .res_valid(res_valid),
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit v, input logic [2:0] o, input longint b);
        longint r;
        bit     f, z;
        r = m_a;
        f = 1'b0;
        z = 1'b0;
        if (rst) begin
            m_a = 0; m_valid = 0; m_ovf = 0; m_dz = 0; m_busy = 0;
        end else begin
            m_valid = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_a = m_pend; m_valid = 1; m_ovf = 0; m_dz = 0;
                end
            end else if (v) begin
                case (o)
                    3'd0: begin r = m_a + b; f = (r >= Mod); end
                    3'd1: begin f = (b > m_a); r = m_a - b + Mod; end
                    3'd2: begin r = m_a * b; f = (r >= Mod); end
                    3'd3: begin
                        if (b == 0) begin
                            r = Mod - 1; z = 1;
                        end else begin
                            m_pend = m_a / b; m_busy = W;
                        end
                    end
                    3'd4: r = b;
                    3'd5: r = 0;
                    default: r = m_a;
                endcase
                if (m_busy == 0) begin
                    m_a = r % Mod; m_ovf = f; m_dz = z; m_valid = 1;
                end
            end
        end
    endtask

    // Called at a negedge: check registered outputs, drive, check ready, clock, update model.
    task automatic cycle(input bit rst, input bit v, input logic [2:0] o, input logic [W-1:0] b);
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        chk("result", 64'(result), 64'(m_a));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("dz", 64'(dz), 64'(m_dz));
        reset    = rst;
        in_valid = v;
        op       = o;
        operand  = b;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!rst && m_busy == 0));
        @(posedge clk);
        model_edge(rst, v, o, longint'(b));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 3'd0; operand = '0;
        m_a = 0; m_pend = 0; m_busy = 0; m_valid = 0; m_ovf = 0; m_dz = 0;
        @(negedge clk);
        model_edge(1'b1, 1'b0, 3'd0, 0);
        cycle(1'b1, 1'b0, OpAdd, 16'd0);

        // Back-to-back adds
        cycle(1'b0, 1'b1, OpAdd, 16'd5);
        cycle(1'b0, 1'b1, OpAdd, 16'd7);
        cycle(1'b0, 1'b0, OpAdd, 16'd0);
        chk("add_chain", 64'(result), 64'd12);

        // Borrow then carry wrap
        cycle(1'b0, 1'b1, OpLoad, 16'd100);
        cycle(1'b0, 1'b1, OpSub, 16'd101);
        chk("sub_borrow_res", 64'(result), 64'hFFFF);
        chk("sub_borrow_ovf", 64'(ovf), 64'd1);
        cycle(1'b0, 1'b1, OpAdd, 16'd1);
        chk("add_carry_res", 64'(result), 64'd0);
        chk("add_carry_ovf", 64'(ovf), 64'd1);

        // Multiply overflow
        cycle(1'b0, 1'b1, OpLoad, 16'd300);
        cycle(1'b0, 1'b1, OpMul, 16'd300);
        chk("mul_res", 64'(result), 64'd24464);
        chk("mul_ovf", 64'(ovf), 64'd1);

        // Division with in_valid held through the busy window
        cycle(1'b0, 1'b1, OpLoad, 16'd1000);
        cycle(1'b0, 1'b1, OpDiv, 16'd7);
        for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, OpAdd, 16'd1);
        chk("div_res", 64'(result), 64'd142);
        chk("div_valid", 64'(res_valid), 64'd1);
        cycle(1'b0, 1'b0, OpAdd, 16'd0);

        // Divide by zero completes in place
        cycle(1'b0, 1'b1, OpLoad, 16'd9);
        cycle(1'b0, 1'b1, OpDiv, 16'd0);
        chk("dz_res", 64'(result), 64'hFFFF);
        chk("dz_flag", 64'(dz), 64'd1);
        cycle(1'b0, 1'b0, OpAdd, 16'd0);

        // Reset in the middle of a division
        cycle(1'b0, 1'b1, OpLoad, 16'd50);
        cycle(1'b0, 1'b1, OpDiv, 16'd3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, OpAdd, 16'd0);
        cycle(1'b1, 1'b0, OpAdd, 16'd0);
        chk("abort_res", 64'(result), 64'd0);
        chk("abort_valid", 64'(res_valid), 64'd0);
        cycle(1'b1, 1'b0, OpAdd, 16'd0);
        for (int i = 0; i < W + 2; i++) cycle(1'b0, 1'b0, OpAdd, 16'd0);
        cycle(1'b0, 1'b1, OpAdd, 16'd4);
        chk("post_abort_add", 64'(result), 64'd4);

        // Random commands, including reserved opcodes and zero divisors
        for (int i = 0; i < 400; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] rb;
            ro = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            cycle(1'b0, $urandom_range(0, 3) != 0, ro, rb);
        end
        cycle(1'b0, 1'b0, OpAdd, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_alu.md
# acc_alu

Parametrised accumulating ALU: each accepted command combines the internal accumulator with a new operand and writes the result back to the accumulator, so results chain from one command to the next. Supports add, subtract, multiply, iterative unsigned divide, load and clear, with per-result overflow and divide-by-zero flags. Sits between a command source using a valid/ready handshake and any consumer of the registered result. It is the scratch arithmetic unit for the core's test datapath.

## Interface
- WIDTH, 16: operand, accumulator and result width in bits (≥ 2).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command this cycle.
- op  in  3  opcode; the encoding is listed under Operation.
- operand  in  WIDTH  unsigned operand, written `B` below.
- result  out  WIDTH  current accumulator value, `A` below.
- res_valid  out  1  one-cycle pulse; result and flags are valid for the command just completed.
- ovf  out  1  overflow or borrow of the completed command.
- dz  out  1  the completed command was a divide by zero.

## Operation
- A command is accepted on a cycle where in_valid and in_ready are both 1. There is no buffering; when in_ready is 0, in_valid is ignored and the source holds the command.
- Opcode encoding:
  - ADD = 0, SUB = 1, MUL = 2, DIV = 3, LOAD = 4, CLR = 5.
  - 6 and 7 are reserved.
- All arithmetic is unsigned, modulo 2^WIDTH.
- Per-opcode behaviour:
  - ADD: A ← A + B; ovf = carry out.
  - SUB: A ← A − B; ovf = borrow (B > A).
  - MUL: A ← low WIDTH bits of A·B; ovf = 1 if any upper WIDTH bits are nonzero.
  - DIV: A ← floor(A / B); ovf = 0.
  - DIV with B = 0: A ← all ones; dz = 1; ovf = 0.
  - LOAD: A ← B.
  - CLR: A ← 0.
  - Reserved opcodes: A is unchanged, flags are 0, res_valid still pulses.
- State machine:
  - IDLE: in_ready = 1. Any accepted non-DIV command, or DIV with B = 0, completes in place and the state stays IDLE. DIV with B ≠ 0 moves to DIV.
  - DIV: in_ready = 0. Runs WIDTH restoring iterations, one quotient bit per cycle. After the last iteration, A is written and the state returns to IDLE.
- ovf and dz are registered alongside result. They hold their values until the next completion overwrites them and are only meaningful while res_valid = 1.

## Timing
- Reset values: A = 0, result = 0, res_valid = 0, ovf = 0, dz = 0, state IDLE, in_ready = 0 while reset = 1.
- Single-cycle commands:
  - Cover every non-DIV command and DIV with B = 0.
  - A command accepted in cycle N produces the updated result and res_valid = 1 in cycle N+1.
  - Back-to-back acceptance is allowed every cycle. Each command uses the A produced by the previous one.
- DIV with B ≠ 0:
  - Accepted in cycle N.
  - in_ready = 0 for cycles N+1 … N+WIDTH.
  - The quotient appears with res_valid = 1 in cycle N+WIDTH+1, and in_ready returns to 1 in that same cycle.
- While a DIV is in progress, result keeps showing the old A; the quotient is written only at completion.
- Reset asserted in any state, including mid-DIV, takes effect at the next clock edge. The division is aborted, every output returns to its reset value, and no res_valid is emitted for the aborted command.

## Structure
- Package acc_alu_pkg:
  - op_e, 3-bit enum: ADD, SUB, MUL, DIV, LOAD, CLR.
  - state_e: IDLE, DIV.
- Sub-module seq_divider:
  - Parametrised by WIDTH.
  - Inputs: start, dividend, divisor. Outputs: done pulse, quotient.
  - Holds the remainder/quotient shift registers and the iteration counter ($clog2(WIDTH+1) bits).
- The top level holds the accumulator, flags, FSM and handshake.

## Test plan
All scenarios use WIDTH = 16.
- Reset, then ADD 5 and ADD 7 in consecutive cycles N and N+1 → result 5 with res_valid in N+1; result 12 with res_valid in N+2; ovf = 0 both times.
- LOAD 100, then SUB 101 → result 0xFFFF, ovf = 1. Then ADD 1 → result 0x0000, ovf = 1.
- LOAD 300, then MUL 300 → result 24464 (90000 mod 65536), ovf = 1.
- LOAD 1000, then DIV 7 accepted in cycle N → in_ready = 0 for N+1 … N+16; result 142 with res_valid in N+17; in_valid held high during the busy window causes no extra acceptance.
- LOAD 9, then DIV 0 → result 0xFFFF, dz = 1 in the next cycle; in_ready never drops.
- LOAD 50, DIV 3, with reset asserted at iteration 5 → the following cycle shows result 0, in_ready 0 while reset is held, and no res_valid; after release, ADD 4 → result 4.
